// File: rtl/memrequest_pkg.sv
// Shared widths, FSM state type and a counter-width helper for the
// memrequest responder and its read pipeline.
package memrequest_pkg;

  localparam int MEMREQ_ADDR_W = 24;
  localparam int MEMREQ_DATA_W = 128;

  typedef enum logic {
    ST_ACTIVE  = 1'b0,
    ST_REFRESH = 1'b1
  } memreq_state_e;

  // Bits needed to hold the values 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/memrequest_read_pipe.sv
// Fixed-latency valid/data shift pipeline for in-flight reads. Empty slots
// carry zero data so the output data is zero whenever valid is low.
module memrequest_read_pipe
  import memrequest_pkg::*;
#(
  parameter int LATENCY = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  input  logic [MEMREQ_DATA_W-1:0] in_data_i,
  output logic                     out_valid_o,
  output logic [MEMREQ_DATA_W-1:0] out_data_o
);

  logic [LATENCY-1:0]       vld_q;
  logic [MEMREQ_DATA_W-1:0] dat_q [LATENCY];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q    <= {vld_q[LATENCY-2:0], in_valid_i};
      dat_q[0] <= in_valid_i ? in_data_i : '0;
      for (int i = 1; i < LATENCY; i++) begin
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_valid_o = vld_q[LATENCY-1];
  assign out_data_o  = dat_q[LATENCY-1];

endmodule

// File: rtl/memrequest_responder.sv
// Word-addressed memory responder with fixed read latency, an in-flight read
// limit, periodic refresh windows and write recovery; busy/write_ready are flops.
module memrequest_responder
  import memrequest_pkg::*;
#(
  parameter int ADDR_WIDTH      = 12,
  parameter int READ_LATENCY    = 6,
  parameter int MAX_OUTSTANDING = 4,
  parameter int REFRESH_PERIOD  = 1024,
  parameter int REFRESH_CYCLES  = 16,
  parameter int WRITE_RECOVERY  = 2
) (
  input  logic                     clk_dram_ctrl,
  input  logic                     rst_dram_ctrl_n,
  input  logic [MEMREQ_ADDR_W-1:0] memrequest_addr,
  input  logic                     memrequest_en,
  input  logic                     memrequest_write_enable,
  input  logic [MEMREQ_DATA_W-1:0] memrequest_write_data,
  output logic                     memrequest_write_ready,
  output logic                     memrequest_busy,
  output logic [MEMREQ_DATA_W-1:0] memrequest_read_data,
  output logic                     memrequest_read_valid
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PER_W = cnt_width(REFRESH_PERIOD - 1);
  localparam int REF_W = cnt_width(REFRESH_CYCLES - 1);
  localparam int OUT_W = cnt_width(MAX_OUTSTANDING);
  localparam int WR_W  = cnt_width(WRITE_RECOVERY);

  memreq_state_e state_q, state_d;
  logic [PER_W-1:0] period_q, period_d;
  logic [REF_W-1:0] refcnt_q, refcnt_d;
  logic [OUT_W-1:0] outst_q, outst_d;
  logic [WR_W-1:0]  wrrec_q, wrrec_d;
  logic             busy_q, busy_d;
  logic             wr_ready_q, wr_ready_d;

  logic [MEMREQ_DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0]    idx;
  logic                     accept, rd_accept, wr_accept;

  // Upper address bits are intentionally dropped so addresses wrap.
  assign idx = memrequest_addr[ADDR_WIDTH-1:0];
  if (ADDR_WIDTH < MEMREQ_ADDR_W) begin : g_addr_wrap
    logic unused_addr_hi;
    assign unused_addr_hi = ^memrequest_addr[MEMREQ_ADDR_W-1:ADDR_WIDTH];
  end

  assign accept    = memrequest_en && !busy_q;
  assign rd_accept = accept && !memrequest_write_enable;
  assign wr_accept = accept && memrequest_write_enable && wr_ready_q;

  always_ff @(posedge clk_dram_ctrl) begin
    if (wr_accept) begin
      mem_q[idx] <= memrequest_write_data;
    end
  end

  always_ff @(posedge clk_dram_ctrl or negedge rst_dram_ctrl_n) begin
    if (!rst_dram_ctrl_n) begin
      state_q    <= ST_ACTIVE;
      period_q   <= '0;
      refcnt_q   <= '0;
      outst_q    <= '0;
      wrrec_q    <= '0;
      busy_q     <= 1'b1;
      wr_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      refcnt_q   <= refcnt_d;
      outst_q    <= outst_d;
      wrrec_q    <= wrrec_d;
      busy_q     <= busy_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    refcnt_d = refcnt_q;
    case (state_q)
      ST_ACTIVE: begin
        if (period_q == PER_W'(REFRESH_PERIOD - 1)) begin
          state_d  = ST_REFRESH;
          period_d = '0;
          refcnt_d = '0;
        end else begin
          period_d = period_q + PER_W'(1);
        end
      end
      ST_REFRESH: begin
        if (refcnt_q == REF_W'(REFRESH_CYCLES - 1)) begin
          state_d  = ST_ACTIVE;
          refcnt_d = '0;
        end else begin
          refcnt_d = refcnt_q + REF_W'(1);
        end
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  always_comb begin
    outst_d = outst_q;
    if (rd_accept && !memrequest_read_valid) begin
      outst_d = outst_q + OUT_W'(1);
    end else if (!rd_accept && memrequest_read_valid) begin
      outst_d = outst_q - OUT_W'(1);
    end
    wrrec_d = wrrec_q;
    if (wr_accept) begin
      wrrec_d = WR_W'(WRITE_RECOVERY);
    end else if (wrrec_q != '0) begin
      wrrec_d = wrrec_q - WR_W'(1);
    end
  end

  // Flags are computed from next state so they already hold in the cycle they describe.
  always_comb begin
    busy_d     = (state_d == ST_REFRESH) || (outst_d == OUT_W'(MAX_OUTSTANDING));
    wr_ready_d = (state_d == ST_ACTIVE) && (wrrec_d == '0);
  end

  assign memrequest_busy        = busy_q;
  assign memrequest_write_ready = wr_ready_q;

  memrequest_read_pipe #(
    .LATENCY (READ_LATENCY)
  ) u_read_pipe (
    .clk_i       (clk_dram_ctrl),
    .rst_ni      (rst_dram_ctrl_n),
    .in_valid_i  (rd_accept),
    .in_data_i   (mem_q[idx]),
    .out_valid_o (memrequest_read_valid),
    .out_data_o  (memrequest_read_data)
  );

endmodule

// File: tb/tb_memrequest_responder.sv
// Directed bench for memrequest_responder: read-after-write, outstanding
// limit, address wrap, write recovery, reset mid-pipeline and refresh window.
module tb_memrequest_responder;

  localparam int RD_LAT  = 6;
  localparam int MAX_OUT = 4;
  localparam int N_LOG   = 1100;

  logic         clk;
  logic         rst_n;
  logic [23:0]  addr;
  logic         en;
  logic         we;
  logic [127:0] wdata;
  logic         wr_ready;
  logic         busy;
  logic [127:0] rdata;
  logic         rv;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;

  logic [127:0] model_mem [4096];
  logic [127:0] exp_q [$];
  int           exp_cyc_q [$];

  bit p22 = 1'b0;
  int resp_in_ref = 0;
  logic busy_log [N_LOG];
  logic wrr_log  [N_LOG];

  memrequest_responder dut (
    .clk_dram_ctrl           (clk),
    .rst_dram_ctrl_n         (rst_n),
    .memrequest_addr         (addr),
    .memrequest_en           (en),
    .memrequest_write_enable (we),
    .memrequest_write_data   (wdata),
    .memrequest_write_ready  (wr_ready),
    .memrequest_busy         (busy),
    .memrequest_read_data    (rdata),
    .memrequest_read_valid   (rv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish by 100000 ns");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: acceptance rule, word storage with wrap, expected responses.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0;
      exp_q.delete();
      exp_cyc_q.delete();
    end else begin
      cyc <= cyc + 1;
      if (en && !busy && (!we || wr_ready)) begin
        if (we) begin
          model_mem[addr[11:0]] <= wdata;
        end else begin
          exp_q.push_back(model_mem[addr[11:0]]);
          exp_cyc_q.push_back(cyc + RD_LAT);
          check("max_outstanding", (exp_q.size() <= MAX_OUT), 1'b1);
        end
      end
    end
  end

  // Scoreboard on the response side.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rv) begin
        if (p22 && !wr_ready) resp_in_ref++;
        if (exp_q.size() == 0) begin
          check("unexpected_rv", rv, 1'b0);
        end else begin
          check("rd_data", rdata, exp_q.pop_front());
          check("rd_latency", cyc, exp_cyc_q.pop_front());
        end
      end else begin
        check("rd_data_idle", rdata, '0);
      end
    end
  end

  task automatic do_req(input logic w, input logic [23:0] a, input logic [127:0] d,
                        output int c);
    int waited;
    waited = 0;
    @(negedge clk);
    en = 1'b1; we = w; addr = a; wdata = d;
    while ((busy || (w && !wr_ready)) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("req_wait_bound", (waited < 100), 1'b1);
    c = cyc;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en = 1'b0; we = 1'b0;
    end
  endtask

  task automatic wait_rv(output int c, output logic [127:0] d);
    bit found;
    found = 1'b0;
    c = -1;
    d = '0;
    @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (rv) begin
        found = 1'b1; c = cyc; d = rdata;
      end else begin
        @(negedge clk);
      end
    end
    check("rv_found", found, 1'b1);
  endtask

  initial begin
    logic [127:0] pat_a5, pat_wrap, pat_da, pat_db, pat_dc, pat_bad, d_v;
    int c_w, c_r, c_v, c_a, c_b, stray, first_low, low_cnt, busy_win;
    int acc [8];

    pat_a5   = {4{32'hA5A5_A5A5}};
    pat_wrap = {4{32'h5A5A_0105}};
    pat_da   = {4{32'hDA00_0020}};
    pat_db   = {4{32'hDB00_0021}};
    pat_dc   = {4{32'hDC00_0022}};
    pat_bad  = {4{32'hBAD0_BAD0}};

    rst_n = 1'b0; en = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b1);
    check("rst_wr_ready", wr_ready, 1'b0);
    check("rst_rv", rv, 1'b0);
    check("rst_rdata", rdata, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_busy", busy, 1'b0);
    check("rel_wr_ready", wr_ready, 1'b1);

    // Read of a word in the cycle right after writing it.
    do_req(1'b1, 24'h000010, pat_a5, c_w);
    do_req(1'b0, 24'h000010, '0, c_r);
    check("raw_accept_gap", c_r - c_w, 1);
    wait_rv(c_v, d_v);
    check("raw_latency", c_v - c_r, RD_LAT);
    check("raw_data", d_v, pat_a5);

    // Back-to-back reads against the outstanding limit.
    for (int i = 0; i < 8; i++) do_req(1'b1, 24'(i), {4{32'hD000_0000 + i}}, c_w);
    idle(4);
    for (int i = 0; i < 8; i++) do_req(1'b0, 24'(i), '0, acc[i]);
    check("b2b_first4", acc[3] - acc[0], 3);
    check("b2b_busy_gap", acc[4] - acc[0], 7);
    check("b2b_last", acc[7] - acc[0], 10);
    idle(12);
    check("b2b_drained", exp_q.size(), 0);

    // Upper address bits ignored.
    do_req(1'b1, 24'h001005, pat_wrap, c_w);
    do_req(1'b0, 24'h000005, '0, c_r);
    wait_rv(c_v, d_v);
    check("wrap_data", d_v, pat_wrap);

    // Write recovery; writes offered while not ready are dropped.
    do_req(1'b1, 24'h000020, pat_da, c_w);
    @(negedge clk);
    check("wr_rec1", wr_ready, 1'b0);
    en = 1'b1; we = 1'b1; addr = 24'h000020; wdata = pat_bad;
    @(negedge clk);
    check("wr_rec2", wr_ready, 1'b0);
    @(negedge clk);
    check("wr_rec_end", wr_ready, 1'b1);
    en = 1'b0;
    do_req(1'b1, 24'h000021, pat_db, c_a);
    do_req(1'b1, 24'h000022, pat_dc, c_b);
    check("wr_gap", c_b - c_a, 3);
    do_req(1'b0, 24'h000020, '0, c_r);
    wait_rv(c_v, d_v);
    check("wr_ignored_data", d_v, pat_da);
    do_req(1'b0, 24'h000021, '0, c_r);
    wait_rv(c_v, d_v);
    check("wr_consec_data", d_v, pat_db);
    idle(8);

    // Reset with reads still in the pipeline.
    for (int i = 0; i < 4; i++) do_req(1'b0, 24'(i + 1), '0, acc[i]);
    idle(3);
    check("pre_rst_rv", rv, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rv", rv, 1'b0);
    check("arst_rdata", rdata, '0);
    check("arst_busy", busy, 1'b1);
    check("arst_wr_ready", wr_ready, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel2_busy", busy, 1'b0);
    check("rel2_wr_ready", wr_ready, 1'b1);
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rv) stray++;
    end
    check("stale_rv", stray, 0);

    // Continuous reads across the first refresh window.
    p22 = 1'b1;
    for (int k = 0; k < 2 * N_LOG; k++) begin
      @(negedge clk);
      if (cyc >= N_LOG) break;
      busy_log[cyc] = busy;
      wrr_log[cyc]  = wr_ready;
      en = 1'b1; we = 1'b0; addr = 24'(cyc % 8);
    end
    idle(12);
    p22 = 1'b0;
    check("ref_drained", exp_q.size(), 0);
    first_low = -1; low_cnt = 0; busy_win = 0;
    for (int i = 12; i < N_LOG; i++) begin
      if (!wrr_log[i]) begin
        low_cnt++;
        if (first_low < 0) first_low = i;
      end
      if (i >= 1024 && i < 1040 && busy_log[i]) busy_win++;
    end
    check("ref_start", first_low, 1024);
    check("ref_wr_low_cycles", low_cnt, 16);
    check("ref_busy_cycles", busy_win, 16);
    check("ref_end_busy", busy_log[1040], 1'b0);
    check("ref_end_wr_ready", wrr_log[1040], 1'b1);
    check("ref_inflight_returned", (resp_in_ref > 0), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memrequest_responder.md
MEMREQUEST_RESPONDER -- requirements
Module: memrequest_responder

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDR_WIDTH, 12: word-address bits decoded.
- READ_LATENCY, 6: accept-to-read_valid cycles, legal range 2..32.
- MAX_OUTSTANDING, 4: in-flight read limit, legal range 1..READ_LATENCY.
- REFRESH_PERIOD, 1024: cycles between refresh windows.
- REFRESH_CYCLES, 16: refresh window length.
- WRITE_RECOVERY, 2: write_ready low cycles after an accepted write.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_dram_ctrl, in, 1: sole clock.
- rst_dram_ctrl_n, in, 1: asynchronous active-low reset.
- memrequest_addr, in, 24: 128-bit word address.
- memrequest_en, in, 1: request strobe.
- memrequest_write_enable, in, 1: 1 = write, 0 = read.
- memrequest_write_data, in, 128: write data.
- memrequest_write_ready, out, 1: a write may be accepted.
- memrequest_busy, out, 1: no request accepted this cycle.
- memrequest_read_data, out, 128: read data.
- memrequest_read_valid, out, 1: one-cycle read-data strobe, no backpressure.

Function
REQ-003 A request SHALL be accepted in a cycle iff memrequest_en=1 and memrequest_busy=0; a write additionally requires memrequest_write_ready=1; a write that lacks write_ready SHALL be ignored with no side effect.
REQ-004 memrequest_busy and memrequest_write_ready SHALL be driven directly from flops (no combinational path from inputs), because the requester gates memrequest_en on them.
REQ-005 Storage SHALL be 2^ADDR_WIDTH x 128 bits; address bits [23:ADDR_WIDTH] SHALL be ignored, so addresses wrap; storage is not reset.
REQ-006 An accepted write SHALL update storage at the clock edge of its accept cycle.
REQ-007 An accepted read SHALL sample storage in its accept cycle; a read accepted the cycle after a write to the same word SHALL return the new data.
REQ-008 A read accepted in cycle N SHALL assert memrequest_read_valid in cycle N+READ_LATENCY with its data; responses SHALL be strictly in order; memrequest_read_data SHALL be zero when read_valid=0.
REQ-009 An outstanding counter (0..MAX_OUTSTANDING) SHALL increment on read accept, decrement on read_valid, and stay unchanged when both occur in the same cycle.
REQ-010 A state machine SHALL have states ACTIVE and REFRESH; reset enters ACTIVE.
REQ-011 A period counter SHALL run in ACTIVE; after REFRESH_PERIOD cycles in ACTIVE the FSM SHALL enter REFRESH for exactly REFRESH_CYCLES cycles, then return to ACTIVE with the period counter cleared.
REQ-012 Registered busy SHALL equal 1 in every REFRESH cycle and in every cycle where the outstanding count equals MAX_OUTSTANDING; its next value SHALL be computed from the next-state FSM and next-state counter so that no acceptance occurs in those cycles.
REQ-013 Reads already in flight SHALL complete on schedule during REFRESH.
REQ-014 memrequest_write_ready SHALL be 0 in REFRESH and for WRITE_RECOVERY cycles following each accepted write, otherwise 1.

Reset
REQ-015 Asserting rst_dram_ctrl_n low SHALL immediately and asynchronously set read_valid=0, read_data=0, busy=1, write_ready=0, state=ACTIVE, and clear all counters and in-flight reads; in-flight reads are discarded, including mid-refresh or mid-pipeline.
REQ-016 In the first clock edge after reset release, busy SHALL go to 0 and write_ready to 1.

Structure
REQ-017 The 24-bit address width, 128-bit data width, and the state enum SHALL reside in shared package memrequest_pkg.
REQ-018 The in-flight read path SHALL be a sub-module memrequest_read_pipe: a READ_LATENCY-deep valid/data shift pipeline.

Verification
REQ-019 Write 0xA5..A5 to address 0x000010 after reset, read it at N+1 -> read_valid at N+1+6 with 0xA5..A5.
REQ-020 Issue back-to-back reads of addresses 0..7 (defaults) -> busy after 4 accepts; 8 responses in address order; never more than 4 outstanding.
REQ-021 Write to 0x001005, read 0x000005 (ADDR_WIDTH=12) -> read returns the written data (wrap).
REQ-022 Hold memrequest_en=1 continuously for 1100 cycles -> busy=1 and write_ready=0 for exactly 16 cycles starting at cycle 1024; in-flight reads still return.
REQ-023 Issue consecutive writes -> write_ready low for 2 cycles after each accept; writes presented while write_ready=0 leave storage unchanged.
REQ-024 Assert reset with 3 reads in flight -> read_valid never asserts for them; after release, outputs match REQ-015 and REQ-016.
